ccg_bist_driver: RTL and testbench

Self-test driver and response reader for generated combinational benchmark circuits. It generates an IN_W-bit stimulus vector stream, captures the OUT_W-bit responses from the circuit under test (CUT), and compacts them into a SIG_W-bit MISR signature. It reports completion and pass/fail against a golden signature. It sits between the dataset test harness and any CUT instance, on the CUT's input and output pins.

---
 rtl/ccg_bist_driver.sv | 149 ++++++++++++++
 tb/tb_ccg_bist_driver.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccg_bist_driver.sv
// BIST driver for combinational benchmark CUTs: LFSR (or counter) stimulus, MISR response compaction.
// Define CCG_BIST_EXHAUSTIVE_EN for an exhaustive 0..2^IN_W-1 counter run instead of the LFSR.
module ccg_bist_driver #(
    parameter int                IN_W      = 11,
    parameter int                OUT_W     = 23,
    parameter int                SIG_W     = 32,
    parameter int                CNT_W     = 16,
    parameter int                N_VEC     = 2047,
    parameter logic [IN_W-1:0]   SEED      = IN_W'(1),
    parameter logic [IN_W-1:0]   TAPS      = IN_W'(11'h500),
    parameter logic [SIG_W-1:0]  MISR_POLY = SIG_W'(32'h04C11DB7),
    parameter int                DUT_LAT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [IN_W-1:0]   stim_o,
    input  logic [OUT_W-1:0]  resp_i,
    input  logic [SIG_W-1:0]  golden_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  sig_o,
    output logic [CNT_W-1:0]  vec_cnt
);

`ifdef CCG_BIST_EXHAUSTIVE_EN
    localparam int              N_RUN      = 1 << IN_W;
    localparam logic [IN_W-1:0] START_STIM = '0;
`else
    localparam int              N_RUN      = N_VEC;
    localparam logic [IN_W-1:0] START_STIM = (SEED == '0) ? IN_W'(1) : SEED;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IN_W-1:0]   stim_reg, stim_next;
    logic [SIG_W-1:0]  sig_reg, sig_next;
    logic [CNT_W-1:0]  vec_cnt_reg, vec_cnt_next;
    logic [CNT_W-1:0]  issue_cnt_reg;
    logic              run_start;
    logic              issue;
    logic              capture;
    logic              last_issue;
    logic              caps_done;
    logic              in_run;

    assign in_run     = (state_reg == RUN) || (state_reg == DRAIN);
    assign issue      = (state_reg == RUN) && !hold;
    assign last_issue = issue && (issue_cnt_reg == CNT_W'(N_RUN - 1));

`ifdef CCG_BIST_EXHAUSTIVE_EN
    assign stim_next = stim_reg + IN_W'(1);
`else
    assign stim_next = (stim_reg >> 1) ^ (stim_reg[0] ? TAPS : '0);
`endif

    assign sig_next     = {sig_reg[SIG_W-2:0], 1'b0}
                        ^ (sig_reg[SIG_W-1] ? MISR_POLY : '0)
                        ^ SIG_W'(resp_i);
    assign vec_cnt_next = vec_cnt_reg + CNT_W'(capture);
    // Counting captures (rather than peeking at the pipe) also covers the capture landing this edge.
    assign caps_done    = (vec_cnt_next == CNT_W'(N_RUN));

    // Valid pipeline mirrors the CUT latency; its tail marks the edge a response is due.
    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign capture = issue;
        end else begin : g_lat
            logic [DUT_LAT-1:0] pipe_reg, pipe_next;
            for (genvar gi = 0; gi < DUT_LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    assign pipe_next[gi] = issue;
                end else begin : g_body
                    assign pipe_next[gi] = pipe_reg[gi-1];
                end
            end
            always_ff @(posedge clk) begin
                if (rst || !in_run) begin
                    pipe_reg <= '0;
                end else begin
                    pipe_reg <= pipe_next;
                end
            end
            assign capture = pipe_reg[DUT_LAT-1];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        run_start  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    run_start  = 1'b1;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_next = caps_done ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (caps_done) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            stim_reg      <= '0;
            sig_reg       <= '0;
            vec_cnt_reg   <= '0;
            issue_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (run_start) begin
                stim_reg      <= START_STIM;
                sig_reg       <= '0;
                vec_cnt_reg   <= '0;
                issue_cnt_reg <= '0;
            end else begin
                if (issue) begin
                    stim_reg      <= stim_next;
                    issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                end
                if (capture) begin
                    sig_reg     <= sig_next;
                    vec_cnt_reg <= vec_cnt_next;
                end
            end
        end
    end

    assign stim_o  = stim_reg;
    assign busy    = in_run;
    assign done    = (state_reg == DONE);
    assign pass    = done && (sig_reg == golden_i);
    assign sig_o   = sig_reg;
    assign vec_cnt = vec_cnt_reg;

endmodule

// File: tb/tb_ccg_bist_driver.sv
// Bench for ccg_bist_driver: four instances (zero/one/CUT responses, latency 0 and 2) against a
// queue-based behavioural model, plus hand-computed literal expectations.
module tb_ccg_bist_driver;
    localparam int NI = 4;
    localparam int NV[NI]  = '{4, 2, 4, 4};
    localparam int LAT[NI] = '{0, 0, 0, 2};
    localparam logic [10:0] TAPS = 11'h500;
    localparam logic [31:0] POLY = 32'h04C11DB7;
`ifdef CCG_BIST_EXHAUSTIVE_EN
    localparam logic [10:0] SEED_EXP  = 11'h000;
    localparam logic [10:0] HOLD_STIM = 11'h002;
`else
    localparam logic [10:0] SEED_EXP  = 11'h001;
    localparam logic [10:0] HOLD_STIM = 11'h280;
`endif
    localparam int BOUND = 5000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, hold = 1'b0;
    logic [10:0] stim   [NI];
    logic [22:0] resp   [NI];
    logic [31:0] golden [NI];
    logic [31:0] sig    [NI];
    logic        busy   [NI];
    logic        done   [NI];
    logic        pass   [NI];
    logic [15:0] vcnt   [NI];
    logic [31:0] gold_b, gold_ref;
    logic [22:0] cut_d1, cut_d2;
    bit          chk_en = 1'b0;
    int          n_chk = 0, n_pass = 0;

    function automatic logic [22:0] cut(input logic [10:0] s);
        return {s, s ^ 11'h5A5, 1'b1};
    endfunction

    function automatic logic [10:0] next_stim(input logic [10:0] s);
`ifdef CCG_BIST_EXHAUSTIVE_EN
        return s + 11'd1;
`else
        return (s >> 1) ^ (s[0] ? TAPS : 11'h000);
`endif
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] g, input logic [22:0] r);
        return {g[30:0], 1'b0} ^ (g[31] ? POLY : 32'h0) ^ {9'h0, r};
    endfunction

    function automatic int run_len(input int i);
`ifdef CCG_BIST_EXHAUSTIVE_EN
        return 2048 + 0 * i;
`else
        return NV[i];
`endif
    endfunction

    function automatic logic [22:0] resp_of(input int i, input logic [10:0] s);
        case (i)
            0:       return 23'h0;
            1:       return 23'h1;
            default: return cut(s);
        endcase
    endfunction

    function automatic logic [31:0] ref_sig(input int n);
        logic [10:0] s = SEED_EXP;
        logic [31:0] g = 32'h0;
        for (int k = 0; k < n; k++) begin
            g = misr(g, cut(s));
            s = next_stim(s);
        end
        return g;
    endfunction

    function automatic logic [10:0] seq_exp(input int k);
`ifdef CCG_BIST_EXHAUSTIVE_EN
        return 11'(k);
`else
        case (k)
            0:       return 11'h001;
            1:       return 11'h500;
            2:       return 11'h280;
            default: return 11'h140;
        endcase
`endif
    endfunction

    // CUT with two register stages for the latency-2 instance.
    always @(posedge clk) begin
        cut_d1 <= cut(stim[3]);
        cut_d2 <= cut_d1;
    end

    assign resp[0]   = 23'h0;
    assign resp[1]   = 23'h1;
    assign resp[2]   = cut(stim[2]);
    assign resp[3]   = cut_d2;
    assign golden[0] = 32'h0;
    assign golden[1] = gold_b;
    assign golden[2] = gold_ref;
    assign golden[3] = gold_ref;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        ccg_bist_driver #(.N_VEC(NV[gi]), .DUT_LAT(LAT[gi])) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .hold     (hold),
            .stim_o   (stim[gi]),
            .resp_i   (resp[gi]),
            .golden_i (golden[gi]),
            .busy     (busy[gi]),
            .done     (done[gi]),
            .pass     (pass[gi]),
            .sig_o    (sig[gi]),
            .vec_cnt  (vcnt[gi])
        );
    end

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d] got %h want %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Behavioural model: issued vectors wait in a queue until their response is due.
    typedef struct {
        int          inst;
        logic [10:0] s;
        int          due;
    } fl_t;
    fl_t         fl[$];
    fl_t         keep[$];
    fl_t         e;
    logic [10:0] m_stim [NI];
    logic [31:0] m_sig  [NI];
    int          m_cnt  [NI];
    int          m_iss  [NI];
    int          m_fl   [NI];
    bit          m_busy [NI];
    bit          m_done [NI];

    always @(posedge clk) begin
        keep.delete();
        foreach (fl[k]) begin
            e = fl[k];
            if (!rst) begin
                e.due = e.due - 1;
                if (e.due == 0) begin
                    m_sig[e.inst] = misr(m_sig[e.inst], resp_of(e.inst, e.s));
                    m_cnt[e.inst]++;
                    m_fl[e.inst]--;
                end else begin
                    keep.push_back(e);
                end
            end
        end
        fl = keep;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_stim[i] = 11'h0; m_sig[i] = 32'h0; m_cnt[i] = 0; m_iss[i] = 0; m_fl[i] = 0;
                m_busy[i] = 1'b0;  m_done[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if (start) begin
                    m_busy[i] = 1'b1; m_done[i] = 1'b0; m_stim[i] = SEED_EXP;
                    m_sig[i]  = 32'h0; m_cnt[i] = 0; m_iss[i] = 0; m_fl[i] = 0;
                end
            end else begin
                if (!hold && m_iss[i] < run_len(i)) begin
                    m_iss[i]++;
                    if (LAT[i] == 0) begin
                        m_sig[i] = misr(m_sig[i], resp_of(i, m_stim[i]));
                        m_cnt[i]++;
                    end else begin
                        fl.push_back('{i, m_stim[i], LAT[i]});
                        m_fl[i]++;
                    end
                    m_stim[i] = next_stim(m_stim[i]);
                end
                if (m_iss[i] == run_len(i) && m_fl[i] == 0) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check("stim", i, stim[i], m_stim[i]);
                check("busy", i, busy[i], m_busy[i]);
                check("done", i, done[i], m_done[i]);
                check("pass", i, pass[i], m_done[i] && (m_sig[i] == golden[i]));
                check("sig",  i, sig[i],  m_sig[i]);
                check("vcnt", i, vcnt[i], m_cnt[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_run(input int hold_at, input int hold_len, input int start_at, input bit first);
        int cyc;
        int bc0;
        int bc3;
        bit fin;
        bc0 = 0; bc3 = 0; fin = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (cyc = 0; cyc < BOUND && !fin; cyc++) begin
            if (busy[0]) bc0++;
            if (busy[3]) bc3++;
            if (first && cyc < 4) check("seq", cyc, stim[0], seq_exp(cyc));
`ifdef CCG_BIST_EXHAUSTIVE_EN
            if (first && cyc < 2048) check("exh_stim", cyc, stim[0], cyc);
`endif
            if (hold_len > 0 && cyc >= hold_at && cyc <= hold_at + hold_len) begin
                check("hold_stim", cyc, stim[0], HOLD_STIM);
                check("hold_vcnt", cyc, vcnt[0], 2);
            end
            hold  = (cyc >= hold_at) && (cyc < hold_at + hold_len);
            start = (cyc == start_at);
            fin   = done[0] && done[1] && done[2] && done[3];
            if (!fin) step();
        end
        hold  = 1'b0;
        start = 1'b0;
        check("run_timeout", -1, fin, 1);
        if (first) begin
            check("busy_cycles_a", 0, bc0, run_len(0));
            check("busy_cycles_d", 3, bc3, run_len(3) + 2);
        end
    endtask

    initial begin
        int cyc;
        bit fin;
        gold_b   = 32'h3;
        gold_ref = ref_sig(run_len(2));

        // Reset with start held high: start must be dropped.
        rst = 1'b1; start = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        check("rst_busy", 0, busy[0], 0);
        check("rst_done", 0, done[0], 0);
        check("rst_pass", 0, pass[0], 0);
        check("rst_stim", 0, stim[0], 0);
        check("rst_sig",  3, sig[3],  0);
        check("rst_vcnt", 0, vcnt[0], 0);

        // Plain run.
        do_run(-1, 0, -1, 1'b1);
        check("a_vcnt", 0, vcnt[0], run_len(0));
        check("a_sig",  0, sig[0],  0);
        check("a_pass", 0, pass[0], 1);
        check("d_sig",  3, sig[3],  gold_ref);
        check("d_pass", 3, pass[3], 1);
`ifndef CCG_BIST_EXHAUSTIVE_EN
        check("b_sig",  1, sig[1],  32'h3);
        check("b_pass", 1, pass[1], 1);
        gold_b = 32'h2;
        #1;
        check("b_pass_bad", 1, pass[1], 0);
        gold_b = 32'h3;
`endif

        // Run with a 3-cycle hold after the 2nd issue and an ignored mid-run start.
        do_run(2, 3, 1, 1'b0);
        check("hold_sig_c", 2, sig[2], gold_ref);
        check("hold_sig_d", 3, sig[3], gold_ref);
        check("hold_vcnt_a", 0, vcnt[0], run_len(0));

        // Reset after two captures, then restart.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid_vcnt", 0, vcnt[0], 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 0, busy[0], 0);
        check("mid_rst_stim", 0, stim[0], 0);
        check("mid_rst_sig",  2, sig[2],  0);
        check("mid_rst_vcnt", 0, vcnt[0], 0);
        check("mid_rst_done", 0, done[0], 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_stim", 0, stim[0], SEED_EXP);
        check("restart_busy", 0, busy[0], 1);
        fin = 1'b0;
        for (cyc = 0; cyc < BOUND && !fin; cyc++) begin
            fin = done[0] && done[1] && done[2] && done[3];
            if (!fin) step();
        end
        check("restart_timeout", -1, fin, 1);
        check("restart_sig", 2, sig[2], gold_ref);

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
